// File: rtl/cave_input_mapper_if.sv
// Bundle between hps_io-side inputs and the conditioned player/service outputs.
// The master drives the raw PS/2 and joystick words, and the mapper (slave) drives the conditioned outputs.
interface cave_input_mapper_if;
    logic [10:0] ps2_key;
    logic [10:0] joystick_0;
    logic [10:0] joystick_1;
    logic [3:0]  p1_dir;
    logic [2:0]  p1_buttons;
    logic        p1_start;
    logic        p1_coin;
    logic [3:0]  p2_dir;
    logic [2:0]  p2_buttons;
    logic        p2_start;
    logic        p2_coin;
    logic [1:0]  service;
    logic        pause_active;

    modport master (
        output ps2_key, joystick_0, joystick_1,
        input  p1_dir, p1_buttons, p1_start, p1_coin,
        input  p2_dir, p2_buttons, p2_start, p2_coin,
        input  service, pause_active
    );

    modport slave (
        input  ps2_key, joystick_0, joystick_1,
        output p1_dir, p1_buttons, p1_start, p1_coin,
        output p2_dir, p2_buttons, p2_start, p2_coin,
        output service, pause_active
    );
endinterface

// File: rtl/cave_input_mapper.sv
// Input conditioning: PS/2 make/break decode merged with joystick words, SOCD filter, coin stretch, pause latch.
// Registered outputs, free-running with no backpressure; key events show 1 cycle after decode, joystick bits on the next edge.
module cave_input_mapper #(
    parameter logic [23:0] COIN_PULSE_CYCLES = 24'd4800000,
    parameter bit          SOCD_NEUTRAL      = 1'b1
) (
    input logic            clock,
    input logic            reset_n,
    cave_input_mapper_if.slave io
);
    logic        toggle_q;
    logic        evt;
    logic        pressed;
    logic [7:0]  code;
    logic [3:0]  k1_dir, k2_dir;
    logic [2:0]  k1_btn, k2_btn;
    logic        k1_start, k2_start, k1_coin, k2_coin, k1_pause;
    logic [1:0]  k_svc;
    logic [3:0]  raw1_dir, raw2_dir;
    logic [1:0]  raw_coin, raw_coin_q, coin_rise;
    logic [1:0][23:0] coin_cnt;
    logic        raw_pause, raw_pause_q, pause_state;
    logic [2:0]  unused_bits;

    assign evt     = io.ps2_key[10] ^ toggle_q;
    assign pressed = io.ps2_key[9];
    assign code    = io.ps2_key[7:0];
    assign unused_bits = {io.ps2_key[8], io.joystick_0[10], io.joystick_1[10]};

    // Joystick bits [3:0] are already ordered {up,down,left,right}.
    assign raw1_dir  = k1_dir | io.joystick_0[3:0];
    assign raw2_dir  = k2_dir | io.joystick_1[3:0];
    assign raw_coin  = {k2_coin | io.joystick_1[8], k1_coin | io.joystick_0[8]};
    assign coin_rise = raw_coin & ~raw_coin_q;
    assign raw_pause = k1_pause | io.joystick_0[9] | io.joystick_1[9];
    assign io.pause_active = pause_state;

    function automatic logic [3:0] socd(input logic [3:0] d);
        logic [3:0] r;
        r = d;
        if (SOCD_NEUTRAL) begin
            if (d[3] && d[2]) r[3:2] = 2'b00;
            if (d[1] && d[0]) r[1:0] = 2'b00;
        end
        return r;
    endfunction

    // toggle_q tracks the toggle even in reset so releasing reset never fakes an event.
    always_ff @(posedge clock) begin
        toggle_q <= io.ps2_key[10];
        if (!reset_n) begin
            k1_dir <= '0; k2_dir <= '0; k1_btn <= '0; k2_btn <= '0;
            k1_start <= 1'b0; k2_start <= 1'b0; k1_coin <= 1'b0; k2_coin <= 1'b0;
            k1_pause <= 1'b0; k_svc <= '0;
        end else if (evt) begin
            case (code)
                8'h75: k1_dir[3] <= pressed;
                8'h72: k1_dir[2] <= pressed;
                8'h6B: k1_dir[1] <= pressed;
                8'h74: k1_dir[0] <= pressed;
                8'h14: k1_btn[0] <= pressed;
                8'h11: k1_btn[1] <= pressed;
                8'h29: k1_btn[2] <= pressed;
                8'h16: k1_start  <= pressed;
                8'h2E: k1_coin   <= pressed;
                8'h4D: k1_pause  <= pressed;
                8'h2D: k2_dir[3] <= pressed;
                8'h2B: k2_dir[2] <= pressed;
                8'h23: k2_dir[1] <= pressed;
                8'h34: k2_dir[0] <= pressed;
                8'h1C: k2_btn[0] <= pressed;
                8'h1B: k2_btn[1] <= pressed;
                8'h15: k2_btn[2] <= pressed;
                8'h1E: k2_start  <= pressed;
                8'h36: k2_coin   <= pressed;
                8'h46: k_svc[0]  <= pressed;
                8'h45: k_svc[1]  <= pressed;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            raw_coin_q      <= '0;
            coin_cnt        <= '0;
            raw_pause_q     <= 1'b0;
            pause_state     <= 1'b0;
            io.p1_dir       <= '0;
            io.p1_buttons   <= '0;
            io.p1_start     <= 1'b0;
            io.p1_coin      <= 1'b0;
            io.p2_dir       <= '0;
            io.p2_buttons   <= '0;
            io.p2_start     <= 1'b0;
            io.p2_coin      <= 1'b0;
            io.service      <= '0;
        end else begin
            raw_coin_q  <= raw_coin;
            raw_pause_q <= raw_pause;
            pause_state <= pause_state ^ (raw_pause & ~raw_pause_q);
            // A rising edge reloads even mid-count, so a fresh coin always gets a full pulse.
            for (int i = 0; i < 2; i++) begin
                if (coin_rise[i])
                    coin_cnt[i] <= COIN_PULSE_CYCLES - 24'd1;
                else if (coin_cnt[i] != '0)
                    coin_cnt[i] <= coin_cnt[i] - 24'd1;
            end
            io.p1_dir     <= socd(raw1_dir);
            io.p1_buttons <= k1_btn | io.joystick_0[6:4];
            io.p1_start   <= k1_start | io.joystick_0[7];
            io.p1_coin    <= raw_coin[0] | (coin_cnt[0] != '0) | coin_rise[0];
            io.p2_dir     <= socd(raw2_dir);
            io.p2_buttons <= k2_btn | io.joystick_1[6:4];
            io.p2_start   <= k2_start | io.joystick_1[7];
            io.p2_coin    <= raw_coin[1] | (coin_cnt[1] != '0) | coin_rise[1];
            io.service    <= k_svc;
        end
    end
endmodule

// File: tb/tb_cave_input_mapper.sv
// Directed bench for cave_input_mapper: stimulus pushes cycle-stamped expectations, a negedge monitor pops and compares.
module tb_cave_input_mapper;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    cave_input_mapper_if bus();
    cave_input_mapper_if bus_ns();
    assign bus_ns.ps2_key    = bus.ps2_key;
    assign bus_ns.joystick_0 = bus.joystick_0;
    assign bus_ns.joystick_1 = bus.joystick_1;

    cave_input_mapper #(.COIN_PULSE_CYCLES(24'd8), .SOCD_NEUTRAL(1'b1)) dut (
        .clock(clk), .reset_n(reset_n), .io(bus));
    cave_input_mapper #(.COIN_PULSE_CYCLES(24'd8), .SOCD_NEUTRAL(1'b0)) dut_ns (
        .clock(clk), .reset_n(reset_n), .io(bus_ns));

    typedef struct {
        int          cyc;
        int          fld;
        logic [31:0] exp;
    } exp_t;

    exp_t  sb[$];
    string names[$];
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] act(input int fld);
        case (fld)
            0:  return {28'd0, bus.p1_dir};
            1:  return {29'd0, bus.p1_buttons};
            3:  return {31'd0, bus.p1_coin};
            4:  return {28'd0, bus.p2_dir};
            6:  return {31'd0, bus.p2_start};
            7:  return {31'd0, bus.p2_coin};
            8:  return {30'd0, bus.service};
            9:  return {31'd0, bus.pause_active};
            10: return {28'd0, bus_ns.p2_dir};
            default: return {11'd0, bus.p1_dir, bus.p1_buttons, bus.p1_start, bus.p1_coin,
                             bus.p2_dir, bus.p2_buttons, bus.p2_start, bus.p2_coin,
                             bus.service, bus.pause_active};
        endcase
    endfunction

    exp_t  mon_e;
    string mon_n;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            mon_n = names.pop_front();
            vectors++;
            if (mon_e.cyc < cyc) begin
                miscompares++;
                $display("FAIL %s: check missed (due cycle %0d, now %0d)", mon_n, mon_e.cyc, cyc);
            end else if (act(mon_e.fld) !== mon_e.exp) begin
                miscompares++;
                $display("FAIL %s @cycle %0d: got %0h expected %0h", mon_n, cyc, act(mon_e.fld), mon_e.exp);
            end
        end
    end

    task automatic chk(input string n, input int fld, input logic [31:0] v, input int d);
        sb.push_back('{cyc + d, fld, v});
        names.push_back(n);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2(input logic p, input logic [7:0] c, input logic e);
        bus.ps2_key = {~bus.ps2_key[10], p, e, c};
    endtask

    initial begin
        reset_n = 1'b0;
        bus.ps2_key = '0;
        bus.joystick_0 = '0;
        bus.joystick_1 = '0;
        step(3);
        chk("reset_all_zero", 11, 0, 0);
        ps2(1'b1, 8'h75, 1'b0);             // event while in reset must be swallowed
        step(2);
        reset_n = 1'b1;
        chk("toggle_in_reset_ignored", 0, 0, 2);
        step(3);

        // PS/2 make/break latency
        ps2(1'b1, 8'h75, 1'b0);
        chk("up_not_yet", 0, 0, 1);
        chk("up_pressed", 0, 4'b1000, 2);
        step(3);
        ps2(1'b0, 8'h75, 1'b0);
        chk("up_released", 0, 0, 2);
        step(3);

        // Unlisted code and extended bit
        ps2(1'b1, 8'h5A, 1'b0);
        chk("unlisted_5a", 11, 0, 2);
        step(3);
        ps2(1'b1, 8'h75, 1'b1);
        chk("up_extended", 0, 4'b1000, 2);
        step(3);
        ps2(1'b0, 8'h75, 1'b1);
        chk("up_ext_release", 0, 0, 2);
        step(3);

        // Buttons and service keys
        ps2(1'b1, 8'h14, 1'b0);
        chk("p1_b1", 1, 3'b001, 2);
        step(3);
        ps2(1'b1, 8'h29, 1'b0);
        chk("p1_b1_b3", 1, 3'b101, 2);
        step(3);
        ps2(1'b0, 8'h14, 1'b0);
        chk("p1_b3_only", 1, 3'b100, 2);
        step(3);
        ps2(1'b0, 8'h29, 1'b0);
        step(3);
        ps2(1'b1, 8'h45, 1'b0);
        chk("service2", 8, 2'b10, 2);
        step(3);
        ps2(1'b0, 8'h45, 1'b0);
        step(3);
        bus.joystick_1[7] = 1'b1;
        chk("p2_start_joy", 6, 1, 1);
        step(2);
        bus.joystick_1[7] = 1'b0;
        step(2);

        // SOCD
        bus.joystick_1[3] = 1'b1;
        chk("p2_up_joy", 4, 4'b1000, 1);
        step(2);
        ps2(1'b1, 8'h2B, 1'b0);
        chk("socd_p2_neutral", 4, 4'b0000, 2);
        chk("socd_off_pass", 10, 4'b1100, 2);
        step(3);
        ps2(1'b0, 8'h2B, 1'b0);
        chk("socd_p2_release", 4, 4'b1000, 2);
        step(3);
        bus.joystick_1[3] = 1'b0;
        chk("p2_up_clear", 4, 0, 1);
        step(2);
        bus.joystick_0[1:0] = 2'b11;
        chk("socd_p1_lr", 0, 0, 1);
        step(2);
        bus.joystick_0[1:0] = 2'b00;
        step(2);

        // Coin: single-cycle pulse stretched to exactly 8
        bus.joystick_0[8] = 1'b1;
        chk("coin_before", 3, 0, 0);
        chk("coin_first", 3, 1, 1);
        chk("coin_last", 3, 1, 8);
        chk("coin_end", 3, 0, 9);
        step(1);
        bus.joystick_0[8] = 1'b0;
        step(12);

        // Coin held for 20 cycles
        bus.joystick_0[8] = 1'b1;
        chk("coin_held_first", 3, 1, 1);
        chk("coin_held_last", 3, 1, 20);
        chk("coin_held_end", 3, 0, 21);
        step(20);
        bus.joystick_0[8] = 1'b0;
        step(4);

        // Coin retrigger at cycle 5
        bus.joystick_0[8] = 1'b1;
        chk("retrig_first", 3, 1, 1);
        chk("retrig_extended", 3, 1, 9);
        chk("retrig_last", 3, 1, 13);
        chk("retrig_end", 3, 0, 14);
        step(1);
        bus.joystick_0[8] = 1'b0;
        step(4);
        bus.joystick_0[8] = 1'b1;
        step(1);
        bus.joystick_0[8] = 1'b0;
        step(12);

        // P2 coin by key tap
        ps2(1'b1, 8'h36, 1'b0);
        chk("p2_coin_before", 7, 0, 1);
        chk("p2_coin_first", 7, 1, 2);
        chk("p2_coin_last", 7, 1, 9);
        chk("p2_coin_end", 7, 0, 10);
        step(1);
        ps2(1'b0, 8'h36, 1'b0);
        step(12);

        // Pause: simultaneous rise toggles once, hold does not retoggle
        bus.joystick_0[9] = 1'b1;
        bus.joystick_1[9] = 1'b1;
        chk("pause_before", 9, 0, 0);
        chk("pause_on", 9, 1, 1);
        chk("pause_held", 9, 1, 100);
        step(100);
        bus.joystick_0[9] = 1'b0;
        bus.joystick_1[9] = 1'b0;
        step(3);
        ps2(1'b1, 8'h4D, 1'b0);
        chk("pause_key_pending", 9, 1, 1);
        chk("pause_off_key", 9, 0, 2);
        step(3);
        ps2(1'b0, 8'h4D, 1'b0);
        chk("pause_key_release", 9, 0, 2);
        step(3);

        // Reset mid coin pulse with pause active
        bus.joystick_0[9] = 1'b1;
        chk("pause_on_again", 9, 1, 1);
        step(1);
        bus.joystick_0[9] = 1'b0;
        bus.joystick_0[8] = 1'b1;
        step(1);
        bus.joystick_0[8] = 1'b0;
        ps2(1'b1, 8'h74, 1'b0);
        step(3);
        chk("pre_reset_coin", 3, 1, 0);
        chk("pre_reset_right", 0, 4'b0001, 0);
        chk("pre_reset_pause", 9, 1, 0);
        reset_n = 1'b0;
        chk("reset_mid_pulse", 11, 0, 1);
        step(2);
        reset_n = 1'b1;
        chk("post_reset_quiet", 11, 0, 3);
        chk("post_reset_late", 11, 0, 12);
        step(14);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            $display("FAIL scoreboard_drain: %0d checks left, expected 0", sb.size());
            vectors += sb.size();
            miscompares += sb.size();
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cave_input_mapper.md
Name: cave_input_mapper

Overview:
- Input conditioning stage between hps_io (ps2_key, joystick_0/1) and the Main input bus (io_joystick_*).
- Replaces the ad-hoc key decoder in the emu wrapper. Decodes PS/2 make/break events, merges them with the joystick words, filters opposing directions, stretches coin pulses and maintains a latched pause state.
- All outputs are registered in the clk_sys domain.

Parameters:
- COIN_PULSE_CYCLES, 24'd4800000, minimum coin output high time in clock cycles (must be ≥1).
- SOCD_NEUTRAL, 1, 1 = both opposing directions active forces both low; 0 = pass through unchanged.

Ports:
- clock  in  1  clk_sys
- reset_n  in  1  synchronous active-low reset
- ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended (ignored), [7:0] scan code
- joystick_0  in  11  player 1 pad: [0]R [1]L [2]D [3]U [4..6]B1..B3 [7]Start [8]Coin [9]Pause
- joystick_1  in  11  player 2 pad, same layout
- p1_dir  out  4  {up,down,left,right}
- p1_buttons  out  3  {b3,b2,b1}
- p1_start  out  1  player 1 start
- p1_coin  out  1  stretched player 1 coin
- p2_dir  out  4  {up,down,left,right}
- p2_buttons  out  3  {b3,b2,b1}
- p2_start  out  1  player 2 start
- p2_coin  out  1  stretched player 2 coin
- service  out  2  {service2,service1}
- pause_active  out  1  latched pause state

Behaviour:
- Reset (reset_n low at a clock edge):
  - All key registers, outputs, coin counters and pause_active go to 0.
  - toggle_q loads ps2_key[10], so no event is generated on release.
  - Reset asserted mid-pulse or mid-pause clears state on the same edge.
- PS/2 event detection:
  - Event at edge N when ps2_key[10] != toggle_q; toggle_q <= ps2_key[10] every cycle.
  - On an event, the key register selected by code is loaded with ps2_key[9]. Unlisted codes are ignored. Bit 8 is ignored.
- Keymap:
  - Player 1: 75 up, 72 down, 6B left, 74 right, 14 b1, 11 b2, 29 b3, 16 start, 2E coin, 4D pause.
  - Player 2: 2D up, 2B down, 23 left, 34 right, 1C b1, 1B b2, 15 b3, 1E start, 36 coin.
  - Service: 46 service1, 45 service2.
- Raw signals: raw = key register OR the corresponding joystick bit. p2 pause comes from joystick_1[9] only.
- Output latency:
  - PS/2 event at edge N updates the key register at N; the output reflects it at N+1.
  - A joystick change before edge N appears at the output at N.
- SOCD (SOCD_NEUTRAL=1): raw up&down both high → up=down=0; left&right likewise. Applied independently per axis and per player.
- Coin stretch, per player:
  - Rising edge of raw coin (raw & ~raw_q) loads the 24-bit counter with COIN_PULSE_CYCLES-1.
  - Otherwise the counter decrements while nonzero and saturates at 0.
  - Registered coin = raw coin | (counter != 0) | rising edge.
  - Result: minimum width is exactly COIN_PULSE_CYCLES cycles; a held coin stays high while held.
  - A rising edge during an active count reloads the counter (retrigger).
- Pause:
  - pause_active toggles at the edge after a rising edge of (p1 pause raw | p2 pause raw).
  - Simultaneous rising edges on both players produce one toggle.
  - Holding pause does not re-toggle.
- No handshake: the block is free-running every cycle.

Test Plan:
1. Reset, then toggle ps2_key[10] with {pressed=1, code=75} → p1_dir=4'b1000 two edges later; toggle again with pressed=0 → p1_dir=0. A toggle during reset_n=0 → no key change.
2. COIN_PULSE_CYCLES=8, joystick_0[8] high for 1 cycle → p1_coin high exactly 8 cycles. Held for 20 cycles → high 20 cycles. Second rising edge at cycle 5 → high until cycle 13.
3. SOCD_NEUTRAL=1: joystick_1[3] and key f (2B) both active → p2_dir[3:2]=00. Release key f → p2_dir=1000. SOCD_NEUTRAL=0 → 1100.
4. joystick_0[9] and joystick_1[9] rise on the same cycle → pause_active 0→1 once. Release both, press key p → back to 0. Holding for 100 cycles → no further toggle.
5. reset_n low mid coin pulse with pause_active=1 → next edge all outputs 0. After release, no spurious coin or key events.
6. Unlisted code 0x5A event and extended-bit variations of code 0x75 → 0x5A has no effect; 0x75 with bit 8 set still maps to p1 up.
